mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 46 ++++
 rtl/byte_lane_merge.sv | 68 ++++++
 rtl/mem_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_pkg
// Shared definitions for the CPU-to-word-memory access controller:
//   - access size encodings as seen on the size port
//   - FSM state encoding of the controller
//   - aligned word-address width and byte-lane count
//   - small helpers classifying an access from its size and low address bits
// -----------------------------------------------------------------------------
package mem_access_pkg;

  // Word memory is addressed on 4-byte boundaries, so only addr[31:2] matters.
  localparam int unsigned ALIGN_W   = 30;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11   // reserved, behaves exactly like SZ_WORD
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Both 10 and 11 are full-word accesses, so bit 1 alone identifies them.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (is_word(size)) begin
      mis = (addr_lo != 2'b00);
    end else if (size == SZ_HALF) begin
      mis = addr_lo[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// -----------------------------------------------------------------------------
// byte_lane_merge
// Purely combinational little-endian lane logic shared by loads and stores.
//   mem_word_i  [31:0] word read from memory
//   wdata_i     [31:0] store data, right-aligned for byte/halfword stores
//   addr_lo_i   [1:0]  byte offset within the word
//   size_i      [1:0]  access size (00 byte, 01 half, 1x word)
//   sign_ext_i         1 = sign-extend subword loads, 0 = zero-extend
//   merged_o    [31:0] mem_word_i with the addressed lanes replaced by wdata_i
//   extracted_o [31:0] addressed lanes of mem_word_i, right-aligned and extended
// -----------------------------------------------------------------------------
module byte_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  output logic [31:0] merged_o,
  output logic [31:0] extracted_o
);

  logic [7:0]           lane [NUM_LANES];
  logic [NUM_LANES-1:0] lane_en;
  logic [31:0]          wdata_rep;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;

  // Replicating the store data across the word lets every lane simply pick
  // its own slice when enabled, independent of the offset.
  always_comb begin
    lane_en   = 4'b1111;
    wdata_rep = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << addr_lo_i;
        wdata_rep = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        lane_en   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane[gi] = mem_word_i[8*gi +: 8];
      assign merged_o[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8] : lane[gi];
    end
  endgenerate

  assign byte_sel = lane[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    extracted_o = mem_word_i;
    case (size_i)
      SZ_BYTE: extracted_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: extracted_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Turns single CPU load/store requests into accesses on a word-wide memory
// with combinational read data. Subword stores are done as read-modify-write.
//   clk, reset       clock; asynchronous active-low reset
//   req, we, size    request strobe (sampled only while ready), store/load, size
//   sign_ext         extension mode for subword loads
//   addr, wdata      byte address and right-aligned store data
//   ready            high only while idle
//   done, err        one-cycle completion pulse; err qualifies done (misaligned)
//   rdata            last load result, held across stores and errors
//   Address, Write_data, MemRead, MemWrite   word memory command
//   Mem_data         memory read data, valid in the cycle MemRead is high
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Mem_data
);

  state_e      state_q;
  logic        ready_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] address_q;
  logic [31:0] write_data_q;
  logic        mem_read_q;
  logic        mem_write_q;

  // Request fields latched at acceptance.
  logic        we_q;
  logic [1:0]  size_q;
  logic        sign_ext_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;

  logic        req_misaligned;
  logic        req_word;
  logic [31:0] merged_word;
  logic [31:0] load_word;

  assign req_misaligned = is_misaligned(size, addr[1:0]);
  assign req_word       = is_word(size);

  // Lane logic works off the live memory data, so both the load result and
  // the RMW merged word are available at the end of the RD cycle.
  byte_lane_merge u_lanes (
    .mem_word_i  (Mem_data),
    .wdata_i     (wdata_q),
    .addr_lo_i   (addr_lo_q),
    .size_i      (size_q),
    .sign_ext_i  (sign_ext_q),
    .merged_o    (merged_word),
    .extracted_o (load_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= '0;
      sign_ext_q   <= 1'b0;
      addr_lo_q    <= '0;
      wdata_q      <= '0;
    end else begin
      // Strobes are single-state; each state re-asserts what it needs.
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q       <= we;
            size_q     <= size;
            sign_ext_q <= sign_ext;
            addr_lo_q  <= addr[1:0];
            wdata_q    <= wdata;
            address_q  <= {addr[31 -: ALIGN_W], 2'b00};
            ready_q    <= 1'b0;
            if (req_misaligned) begin
              // Rejected without touching memory.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (we && req_word) begin
              // Full-word store needs no read-back.
              state_q      <= ST_WR;
              mem_write_q  <= 1'b1;
              write_data_q <= wdata;
            end else begin
              // Loads, and the read half of a subword RMW store.
              state_q    <= ST_RD;
              mem_read_q <= 1'b1;
            end
          end
        end

        ST_RD: begin
          if (we_q) begin
            state_q      <= ST_WR;
            mem_write_q  <= 1'b1;
            write_data_q <= merged_word;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            rdata_q <= load_word;
          end
        end

        ST_WR: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign Address    = address_q;
  assign Write_data = write_data_q;
  assign MemRead    = mem_read_q;
  assign MemWrite   = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Mem_data;

  int n_cmp;
  int n_fail;

  // Word memory model: 64 words, combinational read, write on the rising edge.
  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  assign Mem_data = mem[Address[7:2]];

  always @(posedge clk) begin
    if (MemWrite) mem[Address[7:2]] <= Write_data;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .Address    (Address),
    .Write_data (Write_data),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Mem_data   (Mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mem;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic se,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] ini, input logic [31:0] er,
                              input logic [31:0] em, input logic ee,
                              input int el, input int erd, input int ewr);
    vec_t v;
    v.we = w; v.size = s; v.sext = se; v.addr = a; v.wdata = wd; v.init = ini;
    v.exp_rdata = er; v.exp_mem = em; v.exp_err = ee;
    v.exp_lat = el; v.exp_rd = erd; v.exp_wr = ewr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    int rd_n;
    int wr_n;
    logic addr_ok;
    logic proto_ok;
    logic got_err;
    logic [31:0] got_rdata;
    lat = 0; rd_n = 0; wr_n = 0; addr_ok = 1'b1; proto_ok = 1'b1;
    got_err = 1'b0; got_rdata = '0;
    preload(v.addr[7:2], v.init);
    req = 1'b1; we = v.we; size = v.size; sign_ext = v.sext;
    addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (lat == 0) begin
        if (MemRead) rd_n++;
        if (MemWrite) wr_n++;
        if ((MemRead || MemWrite) && Address !== {v.addr[31:2], 2'b00}) addr_ok = 1'b0;
        if (MemRead && MemWrite) proto_ok = 1'b0;
        if (ready) proto_ok = 1'b0;
        if (!done && err) proto_ok = 1'b0;
        if (done) begin
          lat = c; got_err = err; got_rdata = rdata;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d_err", i), {31'b0, got_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d_rdata", i), got_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rd_cycles", i), rd_n, v.exp_rd);
    chk($sformatf("v%0d_wr_cycles", i), wr_n, v.exp_wr);
    chk($sformatf("v%0d_address", i), {31'b0, addr_ok}, 32'd1);
    chk($sformatf("v%0d_protocol", i), {31'b0, proto_ok}, 32'd1);
    chk($sformatf("v%0d_mem", i), mem[v.addr[7:2]], v.exp_mem);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle_ready", i), {31'b0, ready}, 32'd1);
    chk($sformatf("v%0d_idle_done", i), {31'b0, done}, 32'd0);
    $display("vec %0d: we=%0b size=%0d sext=%0b addr=0x%08h wdata=0x%08h lat=%0d err=%0b rdata=0x%08h mem=0x%08h",
             i, v.we, v.size, v.sext, v.addr, v.wdata, lat, got_err, got_rdata, mem[v.addr[7:2]]);
  endtask

  logic [5:0] rd_pat;
  logic [5:0] dn_pat;
  logic [5:0] rdy_pat;
  int         done_seen;

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;

    //              we size  sx addr   wdata         init          exp_rdata     exp_mem      err lat rd wr
    vecs[0]  = mk(0, 2'b10, 0, 32'h20, 32'h0,        32'hABCD1234, 32'hABCD1234, 32'hABCD1234, 0, 2, 1, 0);
    vecs[1]  = mk(0, 2'b00, 1, 32'h23, 32'h0,        32'hABCD1234, 32'hFFFFFFAB, 32'hABCD1234, 0, 2, 1, 0);
    vecs[2]  = mk(0, 2'b00, 0, 32'h23, 32'h0,        32'hABCD1234, 32'h000000AB, 32'hABCD1234, 0, 2, 1, 0);
    vecs[3]  = mk(0, 2'b01, 1, 32'h22, 32'h0,        32'hABCD1234, 32'hFFFFABCD, 32'hABCD1234, 0, 2, 1, 0);
    vecs[4]  = mk(0, 2'b01, 0, 32'h20, 32'h0,        32'hABCD1234, 32'h00001234, 32'hABCD1234, 0, 2, 1, 0);
    vecs[5]  = mk(0, 2'b00, 1, 32'h21, 32'h0,        32'hABCD1234, 32'h00000012, 32'hABCD1234, 0, 2, 1, 0);
    vecs[6]  = mk(1, 2'b00, 0, 32'h21, 32'hFFFFFF5A, 32'hABCD1234, 32'h00000012, 32'hABCD5A34, 0, 3, 1, 1);
    vecs[7]  = mk(0, 2'b01, 1, 32'h21, 32'h0,        32'hABCD1234, 32'h00000012, 32'hABCD1234, 1, 1, 0, 0);
    vecs[8]  = mk(1, 2'b01, 0, 32'h22, 32'h1234BEEF, 32'hABCD1234, 32'h00000012, 32'hBEEF1234, 0, 3, 1, 1);
    vecs[9]  = mk(1, 2'b10, 0, 32'h24, 32'hCAFEF00D, 32'h11111111, 32'h00000012, 32'hCAFEF00D, 0, 2, 0, 1);
    vecs[10] = mk(0, 2'b10, 0, 32'h26, 32'h0,        32'h11111111, 32'h00000012, 32'h11111111, 1, 1, 0, 0);
    vecs[11] = mk(0, 2'b11, 0, 32'h28, 32'h0,        32'h87654321, 32'h87654321, 32'h87654321, 0, 2, 1, 0);
    vecs[12] = mk(1, 2'b10, 0, 32'h2D, 32'hDEADBEEF, 32'h87654321, 32'h87654321, 32'h87654321, 1, 1, 0, 0);
    vecs[13] = mk(0, 2'b00, 1, 32'h2C, 32'h0,        32'h00000080, 32'hFFFFFF80, 32'h00000080, 0, 2, 1, 0);
    vecs[14] = mk(1, 2'b00, 0, 32'h2F, 32'h00000077, 32'h00000080, 32'hFFFFFF80, 32'h77000080, 0, 3, 1, 1);

    // Reset state, checked before the first clock edge.
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_memread", {31'b0, MemRead}, 32'd0);
    chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("rst_address", Address, 32'h0);
    chk("rst_write_data", Write_data, 32'h0);
    $display("reset: ready=%0b done=%0b rdata=0x%08h", ready, done, rdata);

    // Release with req low: first edge must not start anything.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("release_idle_ready", {31'b0, ready}, 32'd1);
    chk("release_idle_memread", {31'b0, MemRead}, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Back-to-back loads with req held high; the second address changes while busy.
    preload(6'd8, 32'hABCD1234);
    preload(6'd9, 32'h0BADF00D);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; wdata = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      rd_pat[c-1]  = MemRead;
      dn_pat[c-1]  = done;
      rdy_pat[c-1] = ready;
      if (c == 2) begin
        chk("b2b_first_rdata", rdata, 32'hABCD1234);
        addr = 32'h24;
      end
      if (c == 4) req = 1'b0;
      if (c == 5) chk("b2b_second_rdata", rdata, 32'h0BADF00D);
    end
    chk("b2b_memread_pattern", {26'b0, rd_pat}, {26'b0, 6'b001001});
    chk("b2b_done_pattern", {26'b0, dn_pat}, {26'b0, 6'b010010});
    chk("b2b_ready_pattern", {26'b0, rdy_pat}, {26'b0, 6'b100100});
    $display("b2b: memread=%06b done=%06b ready=%06b rdata=0x%08h", rd_pat, dn_pat, rdy_pat, rdata);

    // Reset in the middle of a word store to 0x40.
    preload(6'd16, 32'h0);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h13579BDF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("rmw_in_wr_memwrite", {31'b0, MemWrite}, 32'd1);
    chk("rmw_in_wr_data", Write_data, 32'h13579BDF);
    #2 reset = 1'b0;
    #1;
    chk("rstwr_memwrite_drop", {31'b0, MemWrite}, 32'd0);
    chk("rstwr_ready", {31'b0, ready}, 32'd1);
    chk("rstwr_done", {31'b0, done}, 32'd0);
    chk("rstwr_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("rstwr_no_done", done_seen, 0);
    chk("rstwr_ready_after", {31'b0, ready}, 32'd1);
    chk("rstwr_mem_untouched", mem[16], 32'h0);
    $display("reset_mid_write: done_seen=%0d ready=%0b mem[0x40]=0x%08h", done_seen, ready, mem[16]);

    // High req on the first edge after reset release is accepted.
    @(negedge clk);
    reset = 1'b0;
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h20;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("release_req_memread", {31'b0, MemRead}, 32'd1);
    @(posedge clk); #1;
    chk("release_req_done", {31'b0, done}, 32'd1);
    chk("release_req_rdata", rdata, 32'hABCD1234);
    $display("release_with_req: done=%0b rdata=0x%08h", done, rdata);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
